// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the sequence word fetcher.
package seq_pkg;

  localparam int SEQ_WORD_W   = 64;
  localparam logic [SEQ_WORD_W-1:0] SAFE_WORD = '0;
  localparam int MIN_STEP     = 2;
  localparam int BRAM_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_step_timer.sv
// Loadable down-counter; boundary ticks in the last cycle of each period so
// reloading on the tick gives a period of exactly load_value cycles.
module seq_step_timer #(
  parameter int STEP_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] load_value,
  output logic              boundary
);

  logic [STEP_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign boundary = (count == STEP_W'(1));

endmodule

// File: rtl/sequence_fetch.sv
// Fetches 64-bit sequence words from a 1-cycle BRAM and holds each on seq_data
// for eff_step cycles, using a prefetched shadow word for clean step changes.
//
// state | meaning
// IDLE  | stopped, safe word driven, waiting for start
// PRIME | word 0 read in flight
// RUN   | playing; next word prefetched into shadow
// DONE  | one-shot sequence finished, safe word driven
module sequence_fetch
  import seq_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int STEP_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  loop,
  input  logic [ADDR_W:0]       seq_length,
  input  logic [STEP_W-1:0]     samples_per_step,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [SEQ_WORD_W-1:0] bram_rdata,
  output logic [SEQ_WORD_W-1:0] seq_data,
  output logic                  seq_valid,
  output logic                  step_pulse,
  output logic [ADDR_W-1:0]     step_index,
  output logic                  running,
  output logic                  done
);

  seq_state_e              state;
  logic                    loop_q;
  logic [ADDR_W-1:0]       last_idx_q;
  logic [STEP_W-1:0]       eff_q;
  logic [STEP_W-1:0]       eff_in;
  logic [SEQ_WORD_W-1:0]   shadow;
  logic [BRAM_LATENCY-1:0] rd_pipe;
  logic                    rd_valid;
  logic                    tick;
  logic                    timer_load;

  logic                    accept;
  logic                    stop;
  logic                    prime_load;
  logic                    run_step;
  logic                    finishing;
  logic                    advance;
  logic [ADDR_W-1:0]       new_idx;
  logic                    new_is_last;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    fetch_ok;

  assign eff_in   = (samples_per_step < STEP_W'(MIN_STEP)) ? STEP_W'(MIN_STEP) : samples_per_step;
  assign rd_valid = rd_pipe[BRAM_LATENCY-1];

  assign accept     = ((state == ST_IDLE) || (state == ST_DONE)) && start && enable
                      && (seq_length != '0);
  assign stop       = ((state == ST_PRIME) || (state == ST_RUN)) && !enable;
  assign prime_load = (state == ST_PRIME) && enable && rd_valid;
  assign run_step   = (state == ST_RUN) && enable && tick;
  assign finishing  = run_step && (step_index == last_idx_q) && !loop_q;
  assign advance    = prime_load || (run_step && !finishing);

  // Index of the word about to be presented, and the read that prefetches its successor.
  assign new_idx     = (prime_load || (step_index == last_idx_q)) ? '0 : step_index + ADDR_W'(1);
  assign new_is_last = (new_idx == last_idx_q);
  assign fetch_addr  = new_is_last ? '0 : new_idx + ADDR_W'(1);
  assign fetch_ok    = loop_q || !new_is_last;

  assign timer_load = advance;

  seq_step_timer #(.STEP_W(STEP_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load       (timer_load),
    .load_value (eff_q),
    .boundary   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      loop_q     <= 1'b0;
      last_idx_q <= '0;
      eff_q      <= '0;
      shadow     <= SAFE_WORD;
      rd_pipe    <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      seq_data   <= SAFE_WORD;
      seq_valid  <= 1'b0;
      step_pulse <= 1'b0;
      step_index <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      bram_en    <= 1'b0;
      step_pulse <= 1'b0;
      rd_pipe    <= (rd_pipe << 1) | BRAM_LATENCY'(bram_en);
      if (rd_valid) begin
        shadow <= bram_rdata;
      end

      if (stop) begin
        state     <= ST_IDLE;
        seq_data  <= SAFE_WORD;
        seq_valid <= 1'b0;
        running   <= 1'b0;
      end else if (accept) begin
        state      <= ST_PRIME;
        loop_q     <= loop;
        last_idx_q <= ADDR_W'(seq_length - 1'b1);
        eff_q      <= eff_in;
        done       <= 1'b0;
        running    <= 1'b1;
        bram_en    <= 1'b1;
        bram_addr  <= '0;
      end else if (advance) begin
        // With a 2-cycle step the prefetch lands on the boundary itself, so bypass the shadow.
        state      <= ST_RUN;
        seq_data   <= rd_valid ? bram_rdata : shadow;
        seq_valid  <= 1'b1;
        step_pulse <= 1'b1;
        step_index <= new_idx;
        if (fetch_ok) begin
          bram_en   <= 1'b1;
          bram_addr <= fetch_addr;
        end
      end else if (finishing) begin
        state     <= ST_DONE;
        seq_data  <= SAFE_WORD;
        seq_valid <= 1'b0;
        running   <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule
